// File: rtl/anamux_scan_ctrl.sv
// anamux_scan_ctrl
// Drives the select lines of the analog multiplexer that routes ua[] onto
// the shared analog output path. In auto mode it scans the channels enabled
// in ch_mask, holding each for max(dwell,1) cycles and pulsing sample_stb
// on the last connected cycle. In manual mode it connects man_sel. Every
// change to a different channel opens all switches for BBM_CYCLES cycles
// first, so two switches are never closed at once.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           block enable; 0 opens all switches and returns to IDLE
//   mode_auto     1 = auto scan, 0 = manual
//   man_sel       manual channel index; >= NUM_CH means no connection
//   ch_mask       auto-scan channel enables
//   dwell         connected cycles per channel in auto mode (0 acts as 1)
//   sel_onehot    analog switch enables, at most one bit set
//   sel_idx       index of the last connected channel
//   sample_stb    one-cycle pulse on the final dwell cycle (auto only)
//   busy          high whenever the sequencer is not in IDLE
module anamux_scan_ctrl #(
  parameter int NUM_CH     = 6,
  parameter int DWELL_W    = 8,
  parameter int BBM_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               mode_auto,
  input  logic [2:0]         man_sel,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_CH-1:0]  sel_onehot,
  output logic [2:0]         sel_idx,
  output logic               sample_stb,
  output logic               busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BBM_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam logic [BBM_W-1:0]   BBM_INIT = BBM_W'(BBM_CYCLES - 1);
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] CNT_TWO  = DWELL_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    DWELL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state;
  logic [2:0]         target;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [BBM_W-1:0]   bbm_cnt;
  // Set when the current break ends in IDLE (scan mask emptied) rather
  // than in a new connection.
  logic               brk_to_idle;

  // Lowest set bit of the mask; caller guarantees mask != 0.
  function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[IDX_W'(i)]) r = 3'(i);
    end
    return r;
  endfunction

  // First set bit searching upward from cur+1 with wrap; cur itself is
  // the last candidate. Iterating from the far end lets nearer hits win.
  function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] mask,
                                         input logic [2:0]        cur);
    logic [2:0] r;
    int         idx;
    r = cur;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(cur) + i) % NUM_CH;
      if (mask[IDX_W'(idx)]) r = 3'(idx);
    end
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] to_onehot(input logic [2:0] idx);
    logic [NUM_CH-1:0] r;
    r = '0;
    r[IDX_W'(idx)] = 1'b1;
    return r;
  endfunction

  logic               man_valid;
  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         auto_first;
  logic [2:0]         auto_next;

  assign man_valid  = (int'(man_sel) < NUM_CH);
  assign dwell_eff  = (dwell == '0) ? CNT_ONE : dwell;
  assign auto_first = lowest_ch(ch_mask);
  assign auto_next  = next_ch(ch_mask, sel_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      target      <= '0;
      dwell_cnt   <= '0;
      bbm_cnt     <= '0;
      brk_to_idle <= 1'b0;
      sel_onehot  <= '0;
      sel_idx     <= '0;
      sample_stb  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse unless a branch re-arms it.
      sample_stb <= 1'b0;
      if (!ena) begin
        state       <= IDLE;
        sel_onehot  <= '0;
        busy        <= 1'b0;
        brk_to_idle <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mode_auto && (ch_mask != '0)) begin
              target      <= auto_first;
              state       <= BREAK;
              bbm_cnt     <= BBM_INIT;
              brk_to_idle <= 1'b0;
              busy        <= 1'b1;
            end else if (!mode_auto && man_valid) begin
              target      <= man_sel;
              state       <= BREAK;
              bbm_cnt     <= BBM_INIT;
              brk_to_idle <= 1'b0;
              busy        <= 1'b1;
            end
          end

          BREAK: begin
            if (bbm_cnt != '0) begin
              bbm_cnt <= bbm_cnt - 1'b1;
            end else if (brk_to_idle) begin
              state       <= IDLE;
              busy        <= 1'b0;
              brk_to_idle <= 1'b0;
            end else begin
              sel_onehot <= to_onehot(target);
              sel_idx    <= target;
              if (mode_auto) begin
                state      <= DWELL;
                dwell_cnt  <= dwell_eff;
                sample_stb <= (dwell_eff == CNT_ONE);
              end else begin
                state <= HOLD;
              end
            end
          end

          DWELL: begin
            if (!mode_auto) begin
              // Switched to manual: keep the switch closed if the host
              // picked the channel that is already connected.
              if (!man_valid) begin
                state      <= IDLE;
                sel_onehot <= '0;
                busy       <= 1'b0;
              end else if (man_sel == sel_idx) begin
                state <= HOLD;
              end else begin
                target      <= man_sel;
                state       <= BREAK;
                sel_onehot  <= '0;
                bbm_cnt     <= BBM_INIT;
                brk_to_idle <= 1'b0;
              end
            end else if (dwell_cnt > CNT_ONE) begin
              dwell_cnt  <= dwell_cnt - 1'b1;
              sample_stb <= (dwell_cnt == CNT_TWO);
            end else if (ch_mask == '0) begin
              state       <= BREAK;
              sel_onehot  <= '0;
              bbm_cnt     <= BBM_INIT;
              brk_to_idle <= 1'b1;
            end else if (auto_next == sel_idx) begin
              // Only one channel left in the mask: stay connected.
              dwell_cnt  <= dwell_eff;
              sample_stb <= (dwell_eff == CNT_ONE);
            end else begin
              target      <= auto_next;
              state       <= BREAK;
              sel_onehot  <= '0;
              bbm_cnt     <= BBM_INIT;
              brk_to_idle <= 1'b0;
            end
          end

          HOLD: begin
            if (mode_auto) begin
              if (ch_mask == '0) begin
                state      <= IDLE;
                sel_onehot <= '0;
                busy       <= 1'b0;
              end else if (auto_first == sel_idx) begin
                state      <= DWELL;
                dwell_cnt  <= dwell_eff;
                sample_stb <= (dwell_eff == CNT_ONE);
              end else begin
                target      <= auto_first;
                state       <= BREAK;
                sel_onehot  <= '0;
                bbm_cnt     <= BBM_INIT;
                brk_to_idle <= 1'b0;
              end
            end else if (!man_valid) begin
              state      <= IDLE;
              sel_onehot <= '0;
              busy       <= 1'b0;
            end else if (man_sel != sel_idx) begin
              target      <= man_sel;
              state       <= BREAK;
              sel_onehot  <= '0;
              bbm_cnt     <= BBM_INIT;
              brk_to_idle <= 1'b0;
            end
          end

          default: begin
            state      <= IDLE;
            sel_onehot <= '0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anamux_scan_ctrl.sv
// Directed bench for anamux_scan_ctrl (NUM_CH=6, DWELL_W=8, BBM_CYCLES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_anamux_scan_ctrl;

  localparam int BBM = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       mode_auto;
  logic [2:0] man_sel;
  logic [5:0] ch_mask;
  logic [7:0] dwell;
  logic [5:0] sel_onehot;
  logic [2:0] sel_idx;
  logic       sample_stb;
  logic       busy;

  int checks = 0;
  int passes = 0;

  anamux_scan_ctrl #(
    .NUM_CH    (6),
    .DWELL_W   (8),
    .BBM_CYCLES(BBM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode_auto (mode_auto),
    .man_sel   (man_sel),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel_onehot(sel_onehot),
    .sel_idx   (sel_idx),
    .sample_stb(sample_stb),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every-cycle invariants: one switch at most, strobe only while
  // connected, and a full break between two different connections.
  int         zrun = 0;
  logic [5:0] last_nz = '0;
  always @(negedge clk) begin
    checks++;
    if ($countones(sel_onehot) > 1)
      $display("FAIL onehot_popcount: got %b, want at most one bit set", sel_onehot);
    else passes++;
    checks++;
    if (sample_stb && (sel_onehot == '0))
      $display("FAIL stb_while_open: got sample_stb=1 with sel_onehot=0, want 0");
    else passes++;
    if (sel_onehot != '0) begin
      if ((last_nz != '0) && (sel_onehot != last_nz)) begin
        checks++;
        if (zrun < BBM)
          $display("FAIL bbm_gap: got %0d open cycles between %b and %b, want >= %0d",
                   zrun, last_nz, sel_onehot, BBM);
        else passes++;
      end
      last_nz = sel_onehot;
      zrun    = 0;
    end else begin
      zrun++;
    end
  end

  task automatic do_reset();
    ena       = 1'b0;
    mode_auto = 1'b0;
    man_sel   = 3'd0;
    ch_mask   = 6'b0;
    dwell     = 8'd0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    ena = 1'b0; mode_auto = 1'b0; man_sel = 3'd0; ch_mask = 6'b0; dwell = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sel_onehot, sel_idx, sample_stb, busy} !== 11'd0)
      $display("FAIL reset_outputs: got oh=%b idx=%0d stb=%b busy=%b, want all 0",
               sel_onehot, sel_idx, sample_stb, busy);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel_onehot, busy} !== 7'd0)
      $display("FAIL idle_disabled: got oh=%b busy=%b, want 0 0", sel_onehot, busy);
    else passes++;
  endtask

  task automatic test_auto_scan();
    logic [5:0] exp_oh  [14] = '{6'h00, 6'h00, 6'h01, 6'h01, 6'h01, 6'h00, 6'h00,
                                 6'h04, 6'h04, 6'h04, 6'h00, 6'h00, 6'h01, 6'h01};
    logic       exp_stb [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [2:0] exp_idx [14] = '{0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 0, 0};
    mode_auto = 1'b1;
    ch_mask   = 6'b000101;
    dwell     = 8'd3;
    ena       = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if ((sel_onehot !== exp_oh[c]) || (sample_stb !== exp_stb[c]) ||
          (sel_idx !== exp_idx[c]) || (busy !== 1'b1))
        $display("FAIL auto_scan cyc%0d: got oh=%b stb=%b idx=%0d busy=%b, want oh=%b stb=%b idx=%0d busy=1",
                 c, sel_onehot, sample_stb, sel_idx, busy, exp_oh[c], exp_stb[c], exp_idx[c]);
      else passes++;
    end
  endtask

  // Continues from the auto scan: channel 0 is mid-dwell.
  task automatic test_ena_drop();
    logic [5:0] exp_oh  [3] = '{6'h00, 6'h00, 6'h02};
    logic [2:0] exp_idx [3] = '{2, 2, 1};
    repeat (4) @(negedge clk);
    checks++;
    if ((sel_onehot !== 6'h04) || (sel_idx !== 3'd2))
      $display("FAIL ena_drop_pre: got oh=%b idx=%0d, want oh=000100 idx=2", sel_onehot, sel_idx);
    else passes++;
    ena = 1'b0;
    @(negedge clk);
    checks++;
    if ((sel_onehot !== 6'h00) || (sample_stb !== 1'b0) || (busy !== 1'b0) || (sel_idx !== 3'd2))
      $display("FAIL ena_drop: got oh=%b stb=%b busy=%b idx=%0d, want oh=0 stb=0 busy=0 idx=2",
               sel_onehot, sample_stb, busy, sel_idx);
    else passes++;
    // Lowest set bit is 1; continuing after channel 2 would have picked 4.
    ch_mask = 6'b010010;
    ena     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ((sel_onehot !== exp_oh[c]) || (sel_idx !== exp_idx[c]) || (busy !== 1'b1))
        $display("FAIL ena_resume cyc%0d: got oh=%b idx=%0d busy=%b, want oh=%b idx=%0d busy=1",
                 c, sel_onehot, sel_idx, busy, exp_oh[c], exp_idx[c]);
      else passes++;
    end
  endtask

  task automatic test_dwell_zero();
    do_reset();
    mode_auto = 1'b1;
    ch_mask   = 6'b010000;
    dwell     = 8'd0;
    ena       = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (c < 2) begin
        if ((sel_onehot !== 6'h00) || (sample_stb !== 1'b0))
          $display("FAIL dwell0_break cyc%0d: got oh=%b stb=%b, want oh=0 stb=0",
                   c, sel_onehot, sample_stb);
        else passes++;
      end else begin
        if ((sel_onehot !== 6'h10) || (sample_stb !== 1'b1) || (sel_idx !== 3'd4))
          $display("FAIL dwell0_hold cyc%0d: got oh=%b stb=%b idx=%0d, want oh=010000 stb=1 idx=4",
                   c, sel_onehot, sample_stb, sel_idx);
        else passes++;
      end
    end
  endtask

  task automatic test_manual();
    logic [5:0] exp_oh  [8] = '{6'h00, 6'h00, 6'h08, 6'h08, 6'h00, 6'h00, 6'h20, 6'h20};
    logic [2:0] exp_idx [8] = '{0, 0, 3, 3, 3, 3, 5, 5};
    do_reset();
    mode_auto = 1'b0;
    man_sel   = 3'd3;
    ena       = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ((sel_onehot !== exp_oh[c]) || (sel_idx !== exp_idx[c]) ||
          (sample_stb !== 1'b0) || (busy !== 1'b1))
        $display("FAIL manual cyc%0d: got oh=%b idx=%0d stb=%b busy=%b, want oh=%b idx=%0d stb=0 busy=1",
                 c, sel_onehot, sel_idx, sample_stb, busy, exp_oh[c], exp_idx[c]);
      else passes++;
      if (c == 3) man_sel = 3'd5;
    end
    man_sel = 3'd7;
    @(negedge clk);
    checks++;
    if ((sel_onehot !== 6'h00) || (busy !== 1'b0) || (sel_idx !== 3'd5))
      $display("FAIL manual_invalid: got oh=%b busy=%b idx=%0d, want oh=0 busy=0 idx=5",
               sel_onehot, busy, sel_idx);
    else passes++;
  endtask

  // Manual hold on channel 2, then auto with channel 2 as lowest: the
  // connection must carry straight into the dwell without a break.
  task automatic test_mode_switch();
    logic [5:0] exp_oh  [8] = '{6'h00, 6'h00, 6'h04, 6'h04, 6'h04, 6'h00, 6'h00, 6'h20};
    logic       exp_stb [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic [2:0] exp_idx [8] = '{0, 0, 2, 2, 2, 2, 2, 5};
    do_reset();
    mode_auto = 1'b0;
    man_sel   = 3'd2;
    ena       = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ((sel_onehot !== exp_oh[c]) || (sample_stb !== exp_stb[c]) || (sel_idx !== exp_idx[c]))
        $display("FAIL mode_switch cyc%0d: got oh=%b stb=%b idx=%0d, want oh=%b stb=%b idx=%0d",
                 c, sel_onehot, sample_stb, sel_idx, exp_oh[c], exp_stb[c], exp_idx[c]);
      else passes++;
      if (c == 2) begin
        mode_auto = 1'b1;
        ch_mask   = 6'b100100;
        dwell     = 8'd2;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode_auto = 1'b1;
    ch_mask   = 6'b001000;
    dwell     = 8'd1;
    ena       = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ((sel_onehot !== 6'h08) || (sample_stb !== 1'b1) || (sel_idx !== 3'd3) || (busy !== 1'b1))
      $display("FAIL async_pre: got oh=%b stb=%b idx=%0d busy=%b, want oh=001000 stb=1 idx=3 busy=1",
               sel_onehot, sample_stb, sel_idx, busy);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_onehot, sel_idx, sample_stb, busy} !== 11'd0)
      $display("FAIL async_reset: got oh=%b idx=%0d stb=%b busy=%b, want all 0 before next edge",
               sel_onehot, sel_idx, sample_stb, busy);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_ena_drop();
    test_dwell_zero();
    test_manual();
    test_mode_switch();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/anamux_scan_ctrl.md
Name: anamux_scan_ctrl

Overview:
Digital sequencer that drives the select lines of the on-chip analog multiplexer routing ua[5:0] to the shared analog output path.
- Auto mode: scans a masked set of channels with a programmable dwell time and emits a sample strobe per channel.
- Manual mode: connects a host-selected channel.
- Every channel change is break-before-make, so no two analog switches are ever closed at once.
- Sits between the ui_in/uio_in configuration decode and the analog switch enables.

Parameters:
NUM_CH, 6, number of analog channels (max 8).
DWELL_W, 8, width of the dwell-time input.
BBM_CYCLES, 2, all-switches-open cycles inserted before every new connection (>=1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; 0 forces all switches open
mode_auto  input  1  1 = auto scan, 0 = manual
man_sel  input  3  manual channel index; values >= NUM_CH mean no connection
ch_mask  input  NUM_CH  auto-scan channel enables
dwell  input  DWELL_W  connected cycles per channel in auto mode; 0 is treated as 1
sel_onehot  output  NUM_CH  analog switch enables, at most one bit set
sel_idx  output  3  index of the last connected channel
sample_stb  output  1  one-cycle pulse on the final dwell cycle (auto mode only)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel_onehot=0, sel_idx=0, sample_stb=0, busy=0, counters=0, target=0.
- All outputs are registered.
- Invariant: sel_onehot never changes from one nonzero value to a different nonzero value without at least BBM_CYCLES consecutive cycles of 0 in between.
- Next-channel search (auto): start at (sel_idx+1) mod NUM_CH, wrap, return the first set bit of ch_mask; sel_idx itself is checked last.
- States:
  - IDLE: sel_onehot=0.
    - ena=1, mode_auto=1, ch_mask!=0: target = lowest set bit of ch_mask, go to BREAK.
    - ena=1, mode_auto=0, man_sel<NUM_CH: target = man_sel, go to BREAK.
    - Otherwise stay in IDLE.
  - BREAK: sel_onehot=0 for exactly BBM_CYCLES cycles.
    - Then enter DWELL (auto) or HOLD (manual).
    - On entry: sel_onehot = 1<<target, sel_idx = target.
    - DWELL also loads its counter with max(dwell,1).
  - DWELL: counter decrements each cycle.
    - On the cycle the counter equals 1, sample_stb=1.
    - Next cycle: evaluate ch_mask (sampled on that cycle).
      - mask==0: go to BREAK then IDLE, with switches open.
      - next==sel_idx: stay connected, reload the counter, no break.
      - Otherwise: target=next, go to BREAK.
    - Connection length per channel is max(dwell,1) cycles.
    - dwell and ch_mask changes mid-dwell take effect at the next evaluation only.
  - HOLD: channel stays connected.
    - man_sel changes to a valid different index: target=man_sel, go to BREAK.
    - man_sel becomes invalid: sel_onehot=0, go to IDLE.
    - Same value: no action.
- Mode change in DWELL or HOLD: re-evaluate as in IDLE on the next cycle.
  - If the new target equals sel_idx, keep the connection and move directly to the new state (HOLD, or DWELL with the counter reloaded).
  - Otherwise go to BREAK.
- ena=0 in any state: next cycle sel_onehot=0, sample_stb=0, state=IDLE; sel_idx is retained.
- ena=0 overrides all simultaneous events.
- sample_stb is never asserted in manual mode or while sel_onehot=0.
- Mid-operation reset: outputs clear asynchronously, so the switches open immediately.

Test Plan:
- Reset, then ena=1, auto, ch_mask=6'b000101, dwell=3, BBM=2 -> sel_onehot sequence: 0,0,000001 x3 (stb on 3rd), 0,0,000100 x3 (stb on 3rd), 0,0,000001...; sel_idx alternates 0,2.
- Auto, ch_mask=6'b010000, dwell=0 -> after 2 break cycles, sel_onehot=010000 held continuously, sample_stb every cycle, no further breaks.
- Manual, man_sel=3 then 5 while in HOLD -> 000000 for 2 cycles between 001000 and 100000; sample_stb stays 0; man_sel=7 -> sel_onehot=0, busy=0.
- Auto scan active, ena dropped mid-dwell -> sel_onehot=0 and state=IDLE on the next edge; re-enable resumes from the lowest set bit of ch_mask after BBM.
- rst_n pulsed low mid-DWELL -> sel_onehot=0 asynchronously, before the next clock edge; all outputs at reset values.
- Checker over all tests: popcount(sel_onehot)<=1 and the break-before-make invariant hold every cycle.
